crc_checker: RTL
================

Name: crc_checker

Overview:
Serial CRC receiver/checker, the receive-side counterpart of the team's serial CRC generator. It accepts a codeword MSB-first, one bit per qualified cycle. The codeword is DATA_WIDTH data bits followed by DIV_WIDTH-1 CRC bits. It recovers the parallel data word and flags whether the codeword is divisible by POLY. It sits at the link receive end, ahead of the consumer that latches data_out on done.

Parameters:
DATA_WIDTH, 16, number of data bits per frame.
DIV_WIDTH, 5, divisor width including the leading 1; the CRC field is DIV_WIDTH-1 bits.
POLY, 5'b10011, divisor polynomial. MSB must be 1 and LSB must be 1. Default is x^4+x+1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  marks the first bit of a frame; sampled only when bit_valid=1.
bit_valid  input  1  qualifies bit_in this cycle.
bit_in  input  1  serial codeword bit, MSB first.
busy  output  1  high while a frame is being received.
done  output  1  one-cycle pulse: frame complete, results valid.
crc_ok  output  1  remainder zero; held until the next frame start.
crc_err  output  1  remainder non-zero; held until the next frame start.
data_out  output  DATA_WIDTH  recovered data word; held until the next frame start.

Behaviour:
- Local constant N_BITS = DATA_WIDTH+DIV_WIDTH-1. The bit counter is wide enough to hold N_BITS.
- Reset (rst_n=0 at a clk edge) clears:
  - the FSM to IDLE, the counter, and the remainder register (DIV_WIDTH-1 bits);
  - busy, done, crc_ok, crc_err and data_out, all to 0.
- Reset applies even mid-frame; the partial frame is discarded and no done is produced.
- An accepted bit is any cycle with bit_valid=1. Cycles with bit_valid=0 are stalls: all state holds and done stays 0.
- Remainder update per accepted bit:
  - fb = rem[MSB] ^ bit_in;
  - rem_next = (rem << 1) ^ (fb ? POLY[DIV_WIDTH-2:0] : 0).
  - Remainder zero after all N_BITS bits means the codeword is divisible by POLY.
- Data capture: the first DATA_WIDTH accepted bits shift into a data register MSB first. The remaining DIV_WIDTH-1 bits go only to the remainder.
- FSM states:
  - IDLE: busy=0. On an accepted bit with start=1:
    - load rem from that first bit with rem seeded at 0;
    - count=1, and the data register takes that bit;
    - clear crc_ok and crc_err;
    - go to RECV.
    Accepted bits with start=0 are ignored.
  - RECV: busy=1. Each accepted bit increments count and updates rem and data.
    - On the accepted bit where count reaches N_BITS, go to DONE.
    - start=1 with an accepted bit in RECV aborts the frame: restart exactly as from IDLE, with no done for the aborted frame.
  - DONE (one cycle): done=1, busy=0.
    - data_out takes the data register.
    - crc_ok=(rem==0) and crc_err=~crc_ok.
    - Next state is IDLE.
    - An accepted bit with start=1 in this cycle is treated as the first bit of a new frame (go to RECV), so back-to-back frames lose no bits.
- Latency: done asserts the cycle after the N_BITS-th bit is sampled.
- crc_ok and crc_err are never both 1. Both are 0 from reset until the first done, and both are 0 while a frame is in progress.
- start with bit_valid=0 is ignored in every state.

Test Plan:
1. Reset, then send data 16'h0001 plus CRC 4'b0011 (20 bits, bit_valid continuous) -> done pulses once, 1 cycle after bit 20. data_out=16'h0001, crc_ok=1, crc_err=0.
2. Send data 16'h8000 plus CRC 4'b0011 with bit_valid deasserted for 3 random cycles mid-frame -> done after the 20th accepted bit. data_out=16'h8000, crc_ok=1. busy stays high through the stalls.
3. Send data 16'h0001 plus CRC 4'b0010 (corrupted LSB) -> crc_err=1, crc_ok=0, data_out=16'h0001.
4. After 10 bits of frame A, assert start with a new frame 16'h0000 plus 4'b0000 -> exactly one done, for the new frame: crc_ok=1, data_out=16'h0000.
5. Drive rst_n=0 for one cycle mid-frame, then send a full valid frame -> no done for the aborted frame. Outputs read 0 after reset, then the correct result for the new frame.
6. Send two frames back-to-back, with the second start on the DONE cycle -> two done pulses exactly 20 accepted bits apart, and the first result is held until the second start.

Source files
------------

// File: rtl/crc_checker.sv
// Serial CRC receiver/checker.
// Takes a codeword MSB first, one bit per cycle with bit_valid=1. It recovers the
// DATA_WIDTH-bit data word and reports whether the whole codeword divides evenly by
// POLY. Results are latched on the last accepted bit, so they are already valid in
// the one-cycle done pulse and stay put until the next frame starts.
module crc_checker #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   DIV_WIDTH  = 5,
  parameter logic [DIV_WIDTH-1:0] POLY       = 5'b10011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_ok,
  output logic                  crc_err,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int N_BITS = DATA_WIDTH + DIV_WIDTH - 1;
  localparam int CNT_W  = $clog2(N_BITS + 1);
  localparam int REM_W  = DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  crc_ok_q, crc_ok_d;
  logic                  crc_err_q, crc_err_d;

  // Per-bit arithmetic shared by the next-state logic.
  logic                  fb;
  logic [REM_W-1:0]      rem_step;
  logic [REM_W-1:0]      rem_first;
  logic [DATA_WIDTH-1:0] data_shift;
  logic [CNT_W-1:0]      count_inc;

  // Remainder step, first-bit seed, data shift and counter increment.
  always_comb begin
    fb         = rem_q[REM_W-1] ^ bit_in;
    rem_step   = (rem_q << 1) ^ (fb ? POLY[REM_W-1:0] : '0);
    // The seed is zero, so the feedback bit is just the first codeword bit.
    rem_first  = bit_in ? POLY[REM_W-1:0] : '0;
    data_shift = (data_q << 1) | DATA_WIDTH'(bit_in);
    count_inc  = count_q + CNT_W'(1);
  end

  // Next-state and result logic. An accepted start bit opens a new frame from any
  // state, which covers a mid-frame abort and the back-to-back start in DONE.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    crc_ok_d   = crc_ok_q;
    crc_err_d  = crc_err_q;

    if (bit_valid && start) begin
      state_d   = RECV;
      count_d   = CNT_W'(1);
      rem_d     = rem_first;
      data_d    = DATA_WIDTH'(bit_in);
      crc_ok_d  = 1'b0;
      crc_err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RECV: begin
          if (bit_valid) begin
            count_d = count_inc;
            rem_d   = rem_step;
            if (count_q < CNT_W'(DATA_WIDTH)) begin
              data_d = data_shift;
            end
            if (count_inc == CNT_W'(N_BITS)) begin
              // The last bit is always a CRC bit, so the data register is complete.
              state_d    = DONE;
              data_out_d = data_q;
              crc_ok_d   = (rem_step == '0);
              crc_err_d  = (rem_step != '0);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; a reset mid-frame drops the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign busy     = (state_q == RECV);
  assign done     = (state_q == DONE);
  assign crc_ok   = crc_ok_q;
  assign crc_err  = crc_err_q;
  assign data_out = data_out_q;

endmodule
